if_id_reg: RTL and testbench

IF/ID pipeline register for the five-stage RISC-V pipeline, sitting between the fetch stage and decode. It captures the fetched PC and instruction and holds them when the load-use hazard detector raises `hazard`. It inserts a bubble when a taken branch or jump is resolved. It also extracts the source register numbers (rs1/rs2) that feed straight back into the hazard detector, and drives the PC write-enable so fetch freezes together with this register.

---
 rtl/if_id_reg_pkg.sv | 28 ++
 rtl/if_id_reg_src_reg_extract.sv | 26 ++
 rtl/if_id_reg.sv | 84 ++++++++
 tb/tb_if_id_reg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/if_id_reg_pkg.sv
// Shared constants for the IF/ID register and the source-register extractor.
package if_id_reg_pkg;

   localparam int unsigned RegNumWidth     = 5;
   localparam int unsigned OpcodeWidth     = 7;
   localparam int unsigned InstrWidth      = 32;
   localparam int unsigned StallCntWidth   = 8;
   localparam int unsigned MaxStallDefault = 15;

   localparam logic [InstrWidth-1:0]  NOP_INSTR  = 32'h0000_0013;

   localparam logic [OpcodeWidth-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OpcodeWidth-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OpcodeWidth-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OpcodeWidth-1:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [OpcodeWidth-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OpcodeWidth-1:0] OPC_BRANCH = 7'b1100011;

   // rs1 is meaningless for U-type and JAL encodings
   function automatic logic uses_rs1(input logic [OpcodeWidth-1:0] opcode);
      return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
   endfunction

   function automatic logic uses_rs2(input logic [OpcodeWidth-1:0] opcode);
      return (opcode == OPC_RTYPE) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/if_id_reg_src_reg_extract.sv
// Combinational rs1/rs2 extraction, masking fields the opcode does not read.
module src_reg_extract
   import if_id_reg_pkg::*;
(
   input  logic [InstrWidth-1:0]  instr,
   input  logic                   valid,
   output logic [RegNumWidth-1:0] rs1,
   output logic [RegNumWidth-1:0] rs2
);

   logic [OpcodeWidth-1:0] opcode;
   logic                   unused_bits;

   assign opcode      = instr[6:0];
   assign unused_bits = ^{instr[31:25], instr[14:7]};

   always_comb begin
      rs1 = '0;
      rs2 = '0;
      if (valid) begin
         if (uses_rs1(opcode)) rs1 = instr[19:15];
         if (uses_rs2(opcode)) rs2 = instr[24:20];
      end
   end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load-use hold, branch flush and stall watchdog.
// Optional IF_ID_PERF_CNT_EN adds stallCycles/flushCycles event counters.
module if_id_reg
   import if_id_reg_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned MAX_STALL = MaxStallDefault
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [XLEN-1:0]        pcIn,
   input  logic [XLEN-1:0]        instrIn,
   input  logic                   hazard,
   input  logic                   flush,
   output logic                   pcWriteEnable,
   output logic [XLEN-1:0]        pcOut,
   output logic [XLEN-1:0]        instrOut,
   output logic                   validOut,
   output logic [RegNumWidth-1:0] regNum0,
   output logic [RegNumWidth-1:0] regNum1,
`ifdef IF_ID_PERF_CNT_EN
   output logic [31:0]            stallCycles,
   output logic [31:0]            flushCycles,
`endif
   output logic                   stallTimeout
);

   localparam logic [StallCntWidth-1:0] StallMax = StallCntWidth'(MAX_STALL);
   localparam logic [XLEN-1:0]          NopWord  = XLEN'(NOP_INSTR);

   logic [StallCntWidth-1:0] stall_cnt;
   logic [StallCntWidth-1:0] stall_cnt_inc;

   // Flush must still let fetch advance to the branch target
   assign pcWriteEnable = !hazard || flush;

   assign stall_cnt_inc = (stall_cnt == StallMax) ? stall_cnt
                                                  : stall_cnt + StallCntWidth'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         pcOut        <= '0;
         instrOut     <= NopWord;
         validOut     <= 1'b0;
         stall_cnt    <= '0;
         stallTimeout <= 1'b0;
      end else if (flush) begin
         pcOut     <= pcIn;
         instrOut  <= NopWord;
         validOut  <= 1'b0;
         stall_cnt <= '0;
      end else if (hazard) begin
         stall_cnt <= stall_cnt_inc;
         if (stall_cnt_inc == StallMax) stallTimeout <= 1'b1;
      end else begin
         pcOut     <= pcIn;
         instrOut  <= instrIn;
         validOut  <= 1'b1;
         stall_cnt <= '0;
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   // Event counters follow the same branch priority as the register update
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCycles <= '0;
         flushCycles <= '0;
      end else if (flush) begin
         flushCycles <= flushCycles + 32'd1;
      end else if (hazard) begin
         stallCycles <= stallCycles + 32'd1;
      end
   end
`endif

   src_reg_extract u_src_reg_extract (
      .instr (instrOut[InstrWidth-1:0]),
      .valid (validOut),
      .rs1   (regNum0),
      .rs2   (regNum1)
   );

endmodule

// File: tb/tb_if_id_reg.sv
// Directed, table-driven bench for if_id_reg (XLEN=32, MAX_STALL=15).
module tb_if_id_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pcIn;
   logic [31:0] instrIn;
   logic        hazard;
   logic        flush;
   logic        pcWriteEnable;
   logic [31:0] pcOut;
   logic [31:0] instrOut;
   logic        validOut;
   logic [4:0]  regNum0;
   logic [4:0]  regNum1;
   logic        stallTimeout;
`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stallCycles;
   logic [31:0] flushCycles;
`endif

   int passed = 0;
   int total  = 0;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] ADD  = 32'h0020_81B3;  // add x3,x1,x2
   localparam logic [31:0] ADDI = 32'h0050_0093;  // addi x1,x0,5

   if_id_reg #(.XLEN(32), .MAX_STALL(15)) dut (
      .clk           (clk),
      .reset         (reset),
      .pcIn          (pcIn),
      .instrIn       (instrIn),
      .hazard        (hazard),
      .flush         (flush),
      .pcWriteEnable (pcWriteEnable),
      .pcOut         (pcOut),
      .instrOut      (instrOut),
      .validOut      (validOut),
      .regNum0       (regNum0),
      .regNum1       (regNum1),
`ifdef IF_ID_PERF_CNT_EN
      .stallCycles   (stallCycles),
      .flushCycles   (flushCycles),
`endif
      .stallTimeout  (stallTimeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        rst, hz, fl;
      logic [31:0] pc, ins;
      logic        e_we;
      logic [31:0] e_pc, e_ins;
      logic        e_v;
      logic [4:0]  e_r0, e_r1;
      logic        e_to;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic r, input logic h, input logic f,
                        input logic [31:0] p, input logic [31:0] i);
      reset = r; hazard = h; flush = f; pcIn = p; instrIn = i;
   endtask

   task automatic cyc(input logic r, input logic h, input logic f,
                      input logic [31:0] p, input logic [31:0] i);
      drive(r, h, f, p, i);
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      //          rst  hz   fl   pc            ins            we   e_pc          e_ins          v    r0  r1  to
      vecs[0]  = '{1'b1,1'b0,1'b0,32'h0000_0100,ADD,          1'b1,32'h0,        NOP,           1'b0,5'd0,5'd0,1'b0};
      vecs[1]  = '{1'b0,1'b0,1'b0,32'h0000_0004,ADDI,         1'b1,32'h0000_0004,ADDI,          1'b1,5'd0,5'd0,1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b0,32'h0000_0008,ADD,          1'b1,32'h0000_0008,ADD,           1'b1,5'd1,5'd2,1'b0};
      vecs[3]  = '{1'b0,1'b1,1'b0,32'h0000_000C,32'hDEADBEEF, 1'b0,32'h0000_0008,ADD,           1'b1,5'd1,5'd2,1'b0};
      vecs[4]  = '{1'b0,1'b1,1'b0,32'h0000_000C,32'hDEADBEEF, 1'b0,32'h0000_0008,ADD,           1'b1,5'd1,5'd2,1'b0};
      vecs[5]  = '{1'b0,1'b1,1'b1,32'h0000_000C,32'hDEADBEEF, 1'b1,32'h0000_000C,NOP,           1'b0,5'd0,5'd0,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b0,32'h0000_0010,32'h123452B7, 1'b1,32'h0000_0010,32'h123452B7,  1'b1,5'd0,5'd0,1'b0};
      vecs[7]  = '{1'b0,1'b0,1'b0,32'h0000_0014,32'h0020A423, 1'b1,32'h0000_0014,32'h0020A423,  1'b1,5'd1,5'd2,1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b0,32'h0000_0018,32'h00418063, 1'b1,32'h0000_0018,32'h00418063,  1'b1,5'd3,5'd4,1'b0};
      vecs[9]  = '{1'b0,1'b0,1'b0,32'h0000_001C,32'h000F806F, 1'b1,32'h0000_001C,32'h000F806F,  1'b1,5'd0,5'd0,1'b0};
      vecs[10] = '{1'b1,1'b1,1'b0,32'h0000_0020,ADD,          1'b0,32'h0,        NOP,           1'b0,5'd0,5'd0,1'b0};

      @(posedge clk);
      #1;
      for (int k = 0; k < 11; k++) begin
         drive(vecs[k].rst, vecs[k].hz, vecs[k].fl, vecs[k].pc, vecs[k].ins);
         #1;
         check($sformatf("v%0d pcWriteEnable", k), 32'(pcWriteEnable), 32'(vecs[k].e_we));
         @(posedge clk);
         #1;
         check($sformatf("v%0d pcOut", k),        pcOut,                 vecs[k].e_pc);
         check($sformatf("v%0d instrOut", k),     instrOut,              vecs[k].e_ins);
         check($sformatf("v%0d validOut", k),     32'(validOut),         32'(vecs[k].e_v));
         check($sformatf("v%0d regNum0", k),      32'(regNum0),          32'(vecs[k].e_r0));
         check($sformatf("v%0d regNum1", k),      32'(regNum1),          32'(vecs[k].e_r1));
         check($sformatf("v%0d stallTimeout", k), 32'(stallTimeout),     32'(vecs[k].e_to));
      end

      // Timeout sets on the 15th consecutive stall edge and is sticky until reset
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h40, ADD);
      for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
      check("to after 14 stalls", 32'(stallTimeout), 32'd0);
      check("held pc after 14", pcOut, 32'h40);
      check("held instr after 14", instrOut, ADD);
      cyc(1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
      check("to after 15 stalls", 32'(stallTimeout), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 32'h44, ADDI);
      check("to sticky after release", 32'(stallTimeout), 32'd1);
      check("capture after stall pc", pcOut, 32'h44);
      check("capture after stall instr", instrOut, ADDI);
      cyc(1'b0, 1'b0, 1'b1, 32'h48, ADD);
      check("to sticky over flush", 32'(stallTimeout), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      check("to cleared by reset", 32'(stallTimeout), 32'd0);

      // A non-stall edge restarts the consecutive count
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h50, ADD);
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0, 32'h54, 32'h0);
      check("to after split stalls", 32'(stallTimeout), 32'd0);
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 32'h54, 32'h0);
      check("to after 15 consecutive", 32'(stallTimeout), 32'd1);

      // Flush also restarts the count
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 1'b0, 32'h60, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 32'h64, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 32'h68, 32'h0);
      check("to after flush-split", 32'(stallTimeout), 32'd0);

      // Reset during a 3-cycle stall
      cyc(1'b0, 1'b0, 1'b0, 32'h70, ADD);
      cyc(1'b0, 1'b1, 1'b0, 32'h74, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 32'h74, 32'h0);
      check("mid-stall instr held", instrOut, ADD);
      cyc(1'b1, 1'b1, 1'b0, 32'h74, 32'h0);
      check("reset mid-stall instr", instrOut, NOP);
      check("reset mid-stall valid", 32'(validOut), 32'd0);
      check("reset mid-stall pc", pcOut, 32'h0);
      check("reset mid-stall to", 32'(stallTimeout), 32'd0);

`ifdef IF_ID_PERF_CNT_EN
      check("perf stall after reset", stallCycles, 32'd0);
      check("perf flush after reset", flushCycles, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 32'h80, ADD);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 32'h84, 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 32'h88, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 32'h8C, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h90, ADDI);
      check("perf stallCycles", stallCycles, 32'd4);
      check("perf flushCycles", flushCycles, 32'd2);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
